// File: rtl/num_stepper_pkg.sv
// Shared widths and state encodings for the num_stepper front end.
package num_stepper_pkg;

    localparam int NUM_W = 5;
    localparam logic [NUM_W-1:0] NUM_MAX = 5'd31;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } deb_state_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEAT    = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter-based debouncer for one raw pushbutton;
// emits a one-cycle press_evt on each accepted RELEASED->PRESSED change.
module button_debounce
    import num_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pressed,
    output logic press_evt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             press_q, press_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // The counter's final increment and the state toggle share one edge, so the
    // state flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != logic'(state_q)) begin
            if (cnt_q == CNT_LAST) begin
                state_d = (state_q == RELEASED) ? PRESSED : RELEASED;
                press_d = (state_q == RELEASED);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pressed   = (state_q == PRESSED);
        press_evt = press_q;
    end

endmodule

// File: rtl/num_stepper.sv
// Debounced up/down pushbuttons stepping a wrap-around 5-bit num register.
// Define NUM_STEPPER_AUTO_REPEAT_EN to build in hold-to-repeat scanning.
module num_stepper
    import num_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RESET_VALUE     = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [NUM_W-1:0] num,
    output logic             step
);

    localparam logic [NUM_W-1:0] RESET_NUM = NUM_W'(RESET_VALUE) & NUM_MAX;

    if (DEBOUNCE_CYCLES < 1 || RESET_VALUE < 0 || RESET_VALUE > 31 ||
        REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_param_check
        $error("num_stepper: parameter out of range");
    end

    logic up_evt, dn_evt;
    logic rpt_up, rpt_dn;
`ifdef NUM_STEPPER_AUTO_REPEAT_EN
    logic up_pressed, dn_pressed;
`endif

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_up),
`ifdef NUM_STEPPER_AUTO_REPEAT_EN
        .pressed   (up_pressed),
`else
        .pressed   (),
`endif
        .press_evt (up_evt)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_down),
`ifdef NUM_STEPPER_AUTO_REPEAT_EN
        .pressed   (dn_pressed),
`else
        .pressed   (),
`endif
        .press_evt (dn_evt)
    );

`ifdef NUM_STEPPER_AUTO_REPEAT_EN
    // Intervals below 2 are stretched so step can never be high two cycles running.
    localparam int DELAY_EFF  = (REPEAT_DELAY  < 2) ? 2 : REPEAT_DELAY;
    localparam int PERIOD_EFF = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
    localparam int RPT_MAX    = (DELAY_EFF > PERIOD_EFF) ? DELAY_EFF : PERIOD_EFF;
    localparam int RPT_W      = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(DELAY_EFF - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(PERIOD_EFF - 1);

    rpt_state_e       rpt_state_q, rpt_state_d;
    logic [RPT_W-1:0] rpt_cnt_q,   rpt_cnt_d;
    logic             rpt_dir_up_q, rpt_dir_up_d;
    logic             rpt_abort;
    logic             rpt_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_state_q  <= IDLE;
            rpt_cnt_q    <= '0;
            rpt_dir_up_q <= 1'b0;
        end else begin
            rpt_state_q  <= rpt_state_d;
            rpt_cnt_q    <= rpt_cnt_d;
            rpt_dir_up_q <= rpt_dir_up_d;
        end
    end

    always_comb begin
        rpt_abort = !(rpt_dir_up_q ? up_pressed : dn_pressed) || (up_pressed && dn_pressed);
    end

    always_comb begin
        rpt_state_d  = rpt_state_q;
        rpt_cnt_d    = rpt_cnt_q + RPT_W'(1);
        rpt_dir_up_d = rpt_dir_up_q;
        unique case (rpt_state_q)
            IDLE: begin
                rpt_cnt_d = '0;
                if ((up_evt || dn_evt) && (up_pressed ^ dn_pressed)) begin
                    rpt_state_d  = HOLD_WAIT;
                    rpt_dir_up_d = up_pressed;
                end
            end
            HOLD_WAIT: begin
                if (rpt_abort) begin
                    rpt_state_d = IDLE;
                    rpt_cnt_d   = '0;
                end else if (rpt_cnt_q == DELAY_LAST) begin
                    rpt_state_d = REPEAT;
                    rpt_cnt_d   = '0;
                end
            end
            REPEAT: begin
                if (rpt_abort) begin
                    rpt_state_d = IDLE;
                    rpt_cnt_d   = '0;
                end else if (rpt_cnt_q == PERIOD_LAST) begin
                    rpt_cnt_d = '0;
                end
            end
            default: begin
                rpt_state_d = IDLE;
                rpt_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rpt_fire = !rpt_abort &&
                   (((rpt_state_q == HOLD_WAIT) && (rpt_cnt_q == DELAY_LAST)) ||
                    ((rpt_state_q == REPEAT)    && (rpt_cnt_q == PERIOD_LAST)));
        rpt_up   = rpt_fire &&  rpt_dir_up_q;
        rpt_dn   = rpt_fire && !rpt_dir_up_q;
    end
`else
    always_comb begin
        rpt_up = 1'b0;
        rpt_dn = 1'b0;
    end
`endif

    logic [NUM_W-1:0] num_q,  num_d;
    logic             step_q, step_d;
    logic             inc, dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            num_q  <= RESET_NUM;
            step_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            step_q <= step_d;
        end
    end

    // Simultaneous up and down requests cancel; wrap is plain 5-bit overflow.
    always_comb begin
        inc    = up_evt || rpt_up;
        dec    = dn_evt || rpt_dn;
        num_d  = num_q;
        step_d = 1'b0;
        if (inc ^ dec) begin
            num_d  = inc ? (num_q + NUM_W'(1)) : (num_q - NUM_W'(1));
            step_d = 1'b1;
        end
    end

    always_comb begin
        num  = num_q;
        step = step_q;
    end

endmodule
